// File: rtl/div_arbiter_pkg.sv
`default_nettype none
// div_arbiter_pkg: FSM state and grant-lane encodings plus the default datapath width
// shared by the two-lane divider arbiter and its lane result buffers.
package div_arbiter_pkg;

  localparam int DIV_ARB_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_sel_t;

endpackage
`default_nettype wire

// File: rtl/div_arb_lane_buf.sv
`default_nettype none
// div_arb_lane_buf: one lane's done flag and held quotient/remainder.
// Flush beats ack, ack (only while done) beats load; a held result is never overwritten.
module div_arb_lane_buf
  import div_arbiter_pkg::*;
#(
  parameter int DATA_W = DIV_ARB_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              ack,
  input  logic              flush,
  input  logic [DATA_W-1:0] quotient_in,
  input  logic [DATA_W-1:0] remainder_in,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (flush || (ack && done)) begin
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (load && !done) begin
      done      <= 1'b1;
      quotient  <= quotient_in;
      remainder <= remainder_in;
    end
  end

endmodule
`default_nettype wire

// File: rtl/div_arbiter.sv
`default_nettype none
// div_arbiter: arbitrates two issue lanes onto one shared iterative divider (lane0 first).
// Optional DIV_ARB_RESULT_CACHE_EN keeps the last completed divide and answers repeats without the divider.
module div_arbiter
  import div_arbiter_pkg::*;
#(
  parameter int DATA_W = DIV_ARB_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              excep_flush_i,
  input  logic              lane0_req_i,
  input  logic              lane0_sign_i,
  input  logic [DATA_W-1:0] lane0_dividend_i,
  input  logic [DATA_W-1:0] lane0_divisor_i,
  input  logic              lane0_ack_i,
  output logic              lane0_done_o,
  output logic [DATA_W-1:0] lane0_quotient_o,
  output logic [DATA_W-1:0] lane0_remainder_o,
  input  logic              lane1_req_i,
  input  logic              lane1_sign_i,
  input  logic [DATA_W-1:0] lane1_dividend_i,
  input  logic [DATA_W-1:0] lane1_divisor_i,
  input  logic              lane1_ack_i,
  output logic              lane1_done_o,
  output logic [DATA_W-1:0] lane1_quotient_o,
  output logic [DATA_W-1:0] lane1_remainder_o,
  output logic              div_start_o,
  output logic              div_sign_o,
  output logic [DATA_W-1:0] div_dividend_o,
  output logic [DATA_W-1:0] div_divisor_o,
  input  logic              div_complete_i,
  input  logic [DATA_W-1:0] quotient_i,
  input  logic [DATA_W-1:0] remainder_i
);

  arb_state_t state, next_state;
  lane_sel_t  grant, sel;

  logic              elig0, elig1;
  logic              sel_sign;
  logic [DATA_W-1:0] sel_dividend, sel_divisor;
  logic              grant_en, load0, load1, use_cache;
  logic              cache_hit;
  logic [DATA_W-1:0] hit_q, hit_r, res_q, res_r;

  // A lane already in flight or holding a result must not be granted again.
  assign elig0 = lane0_req_i && !lane0_ack_i && !lane0_done_o
                 && !(state == ST_BUSY && grant == LANE0);
  assign elig1 = lane1_req_i && !lane1_ack_i && !lane1_done_o
                 && !(state == ST_BUSY && grant == LANE1);

  assign sel          = elig0 ? LANE0 : LANE1;
  assign sel_sign     = (sel == LANE0) ? lane0_sign_i     : lane1_sign_i;
  assign sel_dividend = (sel == LANE0) ? lane0_dividend_i : lane1_dividend_i;
  assign sel_divisor  = (sel == LANE0) ? lane0_divisor_i  : lane1_divisor_i;

`ifdef DIV_ARB_RESULT_CACHE_EN
  logic              cache_valid, cache_sign, cache_fill;
  logic [DATA_W-1:0] cache_dividend, cache_divisor, cache_q, cache_r;

  // Drained or flushed completions never reach the cache.
  assign cache_fill = (state == ST_BUSY) && div_complete_i && !excep_flush_i;
  assign cache_hit  = cache_valid && (cache_sign == sel_sign)
                      && (cache_dividend == sel_dividend) && (cache_divisor == sel_divisor);
  assign hit_q      = cache_q;
  assign hit_r      = cache_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_valid    <= 1'b0;
      cache_sign     <= 1'b0;
      cache_dividend <= '0;
      cache_divisor  <= '0;
      cache_q        <= '0;
      cache_r        <= '0;
    end else if (cache_fill) begin
      cache_valid    <= 1'b1;
      cache_sign     <= div_sign_o;
      cache_dividend <= div_dividend_o;
      cache_divisor  <= div_divisor_o;
      cache_q        <= quotient_i;
      cache_r        <= remainder_i;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign hit_q     = '0;
  assign hit_r     = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    grant_en   = 1'b0;
    load0      = 1'b0;
    load1      = 1'b0;
    use_cache  = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((elig0 || elig1) && !excep_flush_i) begin
          if (cache_hit) begin
            use_cache = 1'b1;
            load0     = (sel == LANE0);
            load1     = (sel == LANE1);
          end else begin
            grant_en   = 1'b1;
            next_state = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (div_complete_i) begin
          next_state = ST_IDLE;
          load0      = !excep_flush_i && (grant == LANE0);
          load1      = !excep_flush_i && (grant == LANE1);
        end else if (excep_flush_i) begin
          next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (div_complete_i) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign res_q = use_cache ? hit_q : quotient_i;
  assign res_r = use_cache ? hit_r : remainder_i;

  // Divider operands only change on a grant, so they stay stable until completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_start_o    <= 1'b0;
      grant          <= LANE0;
      div_sign_o     <= 1'b0;
      div_dividend_o <= '0;
      div_divisor_o  <= '0;
    end else begin
      div_start_o <= grant_en;
      if (grant_en) begin
        grant          <= sel;
        div_sign_o     <= sel_sign;
        div_dividend_o <= sel_dividend;
        div_divisor_o  <= sel_divisor;
      end
    end
  end

  div_arb_lane_buf #(.DATA_W(DATA_W)) u_lane0_buf (
    .clk          (clk),
    .rst          (rst),
    .load         (load0),
    .ack          (lane0_ack_i),
    .flush        (excep_flush_i),
    .quotient_in  (res_q),
    .remainder_in (res_r),
    .done         (lane0_done_o),
    .quotient     (lane0_quotient_o),
    .remainder    (lane0_remainder_o)
  );

  div_arb_lane_buf #(.DATA_W(DATA_W)) u_lane1_buf (
    .clk          (clk),
    .rst          (rst),
    .load         (load1),
    .ack          (lane1_ack_i),
    .flush        (excep_flush_i),
    .quotient_in  (res_q),
    .remainder_in (res_r),
    .done         (lane1_done_o),
    .quotient     (lane1_quotient_o),
    .remainder    (lane1_remainder_o)
  );

endmodule
`default_nettype wire

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, operand and result width.
REQ-002 clk  input  1  Single clock; all state on rising edge.
REQ-003 rst  input  1  Asynchronous, active-high reset.
REQ-004 excep_flush_i  input  1  WB exception flush; cancels all lanes.
REQ-005 lane0_req_i, lane1_req_i  input  1 each  Divide request, held high until ack; lane0 is the older issue slot.
REQ-006 laneN_sign_i  input  1  1 = signed divide (div.w/mod.w), 0 = unsigned.
REQ-007 laneN_dividend_i, laneN_divisor_i  input  DATA_W each  Operands, stable while req is high.
REQ-008 laneN_ack_i  input  1  EX stage advance (ready_go && mem_allowin); consumes the held result.
REQ-009 laneN_done_o  output  1  Result valid for lane N, level.
REQ-010 laneN_quotient_o, laneN_remainder_o  output  DATA_W each  Held result for lane N.
REQ-011 div_start_o  output  1  One-cycle start pulse to the shared iterative divider.
REQ-012 div_sign_o, div_dividend_o, div_divisor_o  output  1/DATA_W/DATA_W  Divider operands, registered, stable from start until completion.
REQ-013 div_complete_i  input  1  One-cycle divider completion pulse.
REQ-014 quotient_i, remainder_i  input  DATA_W each  Divider results, valid with div_complete_i.

Function
REQ-015 FSM states: IDLE, BUSY, DRAIN.
REQ-016 A lane is eligible when req=1, it is neither in flight nor holding a result, and its ack is 0 in that cycle.
REQ-017 IDLE: if any lane is eligible and flush=0, grant lane0 before lane1, pulse div_start_o in the next cycle, latch the operands, go to BUSY.
REQ-018 BUSY: on div_complete_i, copy quotient_i/remainder_i into the granted lane's buffer, set laneN_done_o in the next cycle, return to IDLE.
REQ-019 Minimum latency is req to start = 1 cycle and complete to done = 1 cycle; a second grant occurs no earlier than 1 cycle after the previous complete.
REQ-020 laneN_ack_i while done=1 clears done and the buffer in the next cycle; ack while done=0 is ignored.
REQ-021 Flush in BUSY without a same-cycle complete goes to DRAIN; DRAIN waits for div_complete_i, discards the result, then returns to IDLE with no start issued.
REQ-022 Flush clears both laneN_done_o and both buffers in the next cycle, in every state.
REQ-023 Flush and div_complete_i in the same cycle discard the result and go to IDLE.
REQ-024 New grants are blocked while flush=1.
REQ-025 Lane N output registers are not written while that lane holds an unacked result.
REQ-026 The arbiter performs no divide-by-zero trapping; whatever the divider returns is passed through unchanged.

Reset
REQ-027 rst drives the state to IDLE and all outputs and buffers to 0; DRAIN is abandoned.
REQ-028 A div_complete_i arriving after reset with no grant outstanding is ignored.

Configuration
REQ-029 Macro DIV_ARB_RESULT_CACHE_EN present: keep the last completed {sign, dividend, divisor, quotient, remainder} plus a valid bit; an eligible request matching it sets done 1 cycle later with no div_start_o, and lane0 still takes priority.
REQ-030 The cache entry is invalidated only by rst, and is not updated by drained (discarded) results.
REQ-031 Macro absent: no cache storage, and every request uses the divider.

Structure
REQ-032 Shared header DefineDivArb.h: state encodings (IDLE/BUSY/DRAIN), DATA_W default, grant-lane encoding.
REQ-033 Sub-module div_arb_lane_buf holds one lane's done flag and results, with load/ack/flush inputs, instantiated twice.

Verification
REQ-034 Single lane: lane0 unsigned 100/7, divider completes after 33 cycles -> done0=1, q=14, r=2; ack0 -> done0=0 the next cycle.
REQ-035 Both lanes in the same cycle: lane0 signed -9/2, lane1 20/3 -> lane0 served first (q=-4, r=-1), lane1 started 1 cycle after lane0 completes (q=6, r=2).
REQ-036 Flush 5 cycles into a BUSY op -> DRAIN, no done asserted, no start until the complete pulse arrives, then IDLE.
REQ-037 Flush coincident with div_complete_i -> result discarded, both done=0, state IDLE.
REQ-038 Cache enabled: lane0 0x40/0x8 div followed by the same operands for mod -> the second completes 1 cycle after eligibility with no div_start_o, r=0.
REQ-039 Reset asserted during BUSY -> all outputs 0 immediately; a stale div_complete_i afterwards produces no done.
